trap_sequencer: RTL

- Multi-cycle controller that sequences machine-mode trap entry and MRET return for the 5-stage RV64 pipeline.
- Takes exception, interrupt and MRET events at writeback and holds the front end stalled while it flushes every stage.
- Waits for outstanding memory traffic, then drives the CSR write port through mepc, mcause, mtval and mstatus.
- Finally issues a single PC redirect to the trap vector or to mepc.

---
 rtl/trap_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET return sequencer: drains memory, writes
// mepc/mcause/mtval/mstatus through the CSR port, then issues one PC redirect.
module trap_sequencer #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned DRAIN_MAX = 15
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            wb_valid,
  input  logic            wb_illegal,
  input  logic            wb_ecall,
  input  logic            wb_ebreak,
  input  logic            wb_mret,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [31:0]     wb_inst,
  input  logic            ext_irq,
  input  logic            mem_busy,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] mstatus,
  output logic            stall,
  output logic            flush,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            drain_timeout
);

  localparam int unsigned CNT_W = 4;
  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;
  localparam logic [XLEN-1:0] CAUSE_IRQ = {1'b1, {(XLEN-5){1'b0}}, 4'hB};

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_W_MEPC, S_W_MCAUSE, S_W_MTVAL, S_W_MSTATUS, S_REDIRECT
  } state_t;

  state_t            r_state, w_next;
  logic              r_is_ret;
  logic [XLEN-1:0]   r_cause, r_epc, r_tval;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_dto;

  logic              w_illegal, w_ebreak, w_ecall, w_irq, w_mret, w_take;
  logic              w_cap_ret;
  logic [XLEN-1:0]   w_cap_cause, w_cap_tval, w_cap_epc;
  logic              w_cnt_max;
  logic [XLEN-1:0]   w_base, w_vec_off, w_ms;

  assign w_illegal = wb_valid & wb_illegal;
  assign w_ebreak  = wb_valid & wb_ebreak;
  assign w_ecall   = wb_valid & wb_ecall;
  assign w_mret    = wb_valid & wb_mret;
  assign w_irq     = ext_irq & mstatus[3];
  assign w_take    = w_illegal | w_ebreak | w_ecall | w_irq | w_mret;
  assign w_cnt_max = (r_cnt == CNT_W'(DRAIN_MAX));
  assign w_base    = {mtvec[XLEN-1:2], 2'b00};
  assign w_vec_off = XLEN'({r_cause[5:0], 2'b00});
  assign drain_timeout = r_dto;

  // Priority encode the writeback/interrupt event into kind, cause and tval
  always_comb begin
    w_cap_ret   = 1'b0;
    w_cap_cause = '0;
    w_cap_tval  = '0;
    w_cap_epc   = wb_valid ? wb_pc : '0;
    if (w_illegal) begin
      w_cap_cause = XLEN'(2);
      w_cap_tval  = XLEN'(wb_inst);
    end else if (w_ebreak) begin
      w_cap_cause = XLEN'(3);
      w_cap_tval  = wb_pc;
    end else if (w_ecall) begin
      w_cap_cause = XLEN'(11);
    end else if (w_irq) begin
      w_cap_cause = CAUSE_IRQ;
    end else if (w_mret) begin
      w_cap_ret   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_is_ret <= 1'b0;
      r_cause  <= '0;
      r_epc    <= '0;
      r_tval   <= '0;
      r_cnt    <= '0;
      r_dto    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_take) begin
        r_is_ret <= w_cap_ret;
        r_cause  <= w_cap_cause;
        r_epc    <= w_cap_epc;
        r_tval   <= w_cap_tval;
      end
      r_cnt <= (r_state == S_DRAIN) ? r_cnt + CNT_W'(1) : '0;
      if (r_state == S_DRAIN && mem_busy && w_cnt_max) r_dto <= 1'b1;
    end
  end

  // Next state and Moore output decode
  always_comb begin
    w_next         = r_state;
    stall          = (r_state != S_IDLE);
    flush          = (r_state != S_IDLE);
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    w_ms           = mstatus;
    case (r_state)
      S_IDLE: if (w_take) w_next = S_DRAIN;
      S_DRAIN: begin
        if (!mem_busy || w_cnt_max) w_next = r_is_ret ? S_W_MSTATUS : S_W_MEPC;
      end
      S_W_MEPC: begin
        csr_we    = 1'b1;
        csr_waddr = A_MEPC;
        csr_wdata = {r_epc[XLEN-1:2], 2'b00};
        w_next    = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = A_MCAUSE;
        csr_wdata = r_cause;
        w_next    = S_W_MTVAL;
      end
      S_W_MTVAL: begin
        csr_we    = 1'b1;
        csr_waddr = A_MTVAL;
        csr_wdata = r_tval;
        w_next    = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        if (r_is_ret) begin
          w_ms[3] = mstatus[7];
          w_ms[7] = 1'b1;
        end else begin
          w_ms[7] = mstatus[3];
          w_ms[3] = 1'b0;
        end
        w_ms[12:11] = 2'b11;
        csr_we    = 1'b1;
        csr_waddr = A_MSTATUS;
        csr_wdata = w_ms;
        w_next    = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        if (r_is_ret)
          redirect_pc = mepc;
        else if (mtvec[1:0] == 2'b01 && r_cause[XLEN-1])
          redirect_pc = w_base + w_vec_off;
        else
          redirect_pc = w_base;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
